pipe_operand_driver: RTL and testbench

Upstream driver for the pipelined multiply stage. It buffers a burst of operand pairs, then replays them with the stage's enable protocol: increment_enable first, then multiply_enable, with each pair held for HOLD cycles. It also captures the stage's returned e values into a registered result stream. It sits between the image-stage controller and the multiply pipeline, and is the sending end of the a/b/enable interface.

---
 rtl/pipe_drv_pkg.sv | 20 ++
 rtl/pipe_operand_driver_fifo.sv | 65 ++++++
 rtl/pipe_operand_driver.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_operand_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_drv_pkg.sv
// Shared types and default widths for the operand driver that feeds the pipelined multiply stage.
package pipe_drv_pkg;

  localparam int WIDTH_D   = 4;
  localparam int E_WIDTH_D = 9;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    FLUSH,
    DONE
  } state_t;

  typedef struct packed {
    logic [WIDTH_D-1:0] a;
    logic [WIDTH_D-1:0] b;
  } pair_t;

endpackage

// File: rtl/pipe_operand_driver_fifo.sv
// operand_fifo: DEPTH-entry synchronous FIFO of operand pairs with a show-ahead head.
module operand_fifo
  import pipe_drv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pair_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/pipe_operand_driver.sv
// Buffers a burst of operand pairs and replays them into the multiply stage, capturing returned e.
// Define PIPE_DRV_CHECK_EN to compare each captured e against a*b and raise a sticky mismatch.
//
// state | meaning
// IDLE  | accepting loads, waiting for start
// ARM   | increment_enable only, head pair presented
// RUN   | both enables, each pair held HOLD cycles then popped
// FLUSH | increment_enable only, PIPE_LAT+1 cycles to drain tags
// DONE  | one-cycle done pulse
module pipe_operand_driver
  import pipe_drv_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = WIDTH_D,
  parameter int E_WIDTH  = E_WIDTH_D,
  parameter int HOLD     = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pair_valid,
  input  logic [WIDTH-1:0]   pair_a,
  input  logic [WIDTH-1:0]   pair_b,
  output logic               pair_ready,
  input  logic               start,
  output logic               increment_enable,
  output logic               multiply_enable,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [E_WIDTH-1:0] e,
  output logic [E_WIDTH-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic               done,
  output logic               mismatch
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(HOLD + PIPE_LAT + 1);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic [E_WIDTH-1:0]  result_q, result_d;
  logic                result_valid_q, result_valid_d;

  opnd_t               head, load_pair;
  logic [CW-1:0]       count;
  logic                full, empty;
  logic                push, pop, inject, drive_head, start_acc, tag_exit;

  assign load_pair  = '{a: pair_a, b: pair_b};
  assign pair_ready = (state_q == IDLE) && !full && !start;
  assign push       = pair_valid && pair_ready;

  operand_fifo #(
    .DEPTH (DEPTH),
    .T     (opnd_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (load_pair),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    tmr_d            = tmr_q;
    pop              = 1'b0;
    inject           = 1'b0;
    start_acc        = 1'b0;
    drive_head       = 1'b0;
    increment_enable = 1'b0;
    multiply_enable  = 1'b0;
    done             = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = empty ? DONE : ARM;
        end
      end
      ARM: begin
        increment_enable = 1'b1;
        drive_head       = 1'b1;
        tmr_d            = TW'(HOLD - 1);
        state_d          = RUN;
      end
      RUN: begin
        increment_enable = 1'b1;
        multiply_enable  = 1'b1;
        drive_head       = 1'b1;
        if (tmr_q == '0) begin
          pop    = 1'b1;
          inject = 1'b1;
          tmr_d  = TW'(HOLD - 1);
          // The pop of the final pair hands over to the drain timer.
          if (count == CW'(1)) begin
            tmr_d   = TW'(PIPE_LAT);
            state_d = FLUSH;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      FLUSH: begin
        increment_enable = 1'b1;
        if (tmr_q == '0) begin
          state_d = DONE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign a    = drive_head ? head.a : '0;
  assign b    = drive_head ? head.b : '0;

  assign tag_exit = tag_q[PIPE_LAT-1];

  always_comb begin
    tag_d[0] = inject;
    for (int i = 1; i < PIPE_LAT; i++) tag_d[i] = tag_q[i-1];
    result_d       = tag_exit ? e : result_q;
    result_valid_d = tag_exit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      tag_q          <= tag_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

`ifdef PIPE_DRV_CHECK_EN
  opnd_t              pay_q [PIPE_LAT];
  opnd_t              pay_d [PIPE_LAT];
  logic               mismatch_q, mismatch_d;
  logic [E_WIDTH-1:0] expect_e;

  assign expect_e = E_WIDTH'(pay_q[PIPE_LAT-1].a) * E_WIDTH'(pay_q[PIPE_LAT-1].b);

  // Payload shifts in lockstep with the tag bits; only slots carrying a tag are ever compared.
  always_comb begin
    pay_d[0] = head;
    for (int i = 1; i < PIPE_LAT; i++) pay_d[i] = pay_q[i-1];
    mismatch_d = mismatch_q;
    if (start_acc) begin
      mismatch_d = 1'b0;
    end else if (tag_exit && (e != expect_e)) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pay_q[i] <= '0;
      mismatch_q <= 1'b0;
    end else begin
      pay_q      <= pay_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_operand_driver.sv
// Scoreboard bench for pipe_operand_driver: a behavioural multiply stage returns e, expected results are queued at start.
module tb_pipe_operand_driver;

  localparam int DEPTH    = 4;
  localparam int WIDTH    = 4;
  localparam int E_WIDTH  = 9;
  localparam int HOLD     = 2;
  localparam int PIPE_LAT = 2;
`ifdef PIPE_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               pair_valid;
  logic [WIDTH-1:0]   pair_a, pair_b;
  logic               pair_ready;
  logic               start;
  logic               increment_enable, multiply_enable;
  logic [WIDTH-1:0]   a, b;
  logic [E_WIDTH-1:0] e;
  logic [E_WIDTH-1:0] result;
  logic               result_valid, busy, done, mismatch;

  pipe_operand_driver #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .E_WIDTH(E_WIDTH), .HOLD(HOLD), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .pair_valid(pair_valid), .pair_a(pair_a), .pair_b(pair_b), .pair_ready(pair_ready),
    .start(start),
    .increment_enable(increment_enable), .multiply_enable(multiply_enable),
    .a(a), .b(b), .e(e),
    .result(result), .result_valid(result_valid),
    .busy(busy), .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiply stage: product of a/b, delayed PIPE_LAT edges; bad_53 corrupts 5*3 to 16.
  logic               bad_53 = 1'b0;
  logic [E_WIDTH-1:0] prod_pipe [PIPE_LAT];
  always @(posedge clk) begin
    logic [E_WIDTH-1:0] p;
    p = E_WIDTH'(a) * E_WIDTH'(b);
    if (bad_53 && a == 4'd5 && b == 4'd3) p = 9'd16;
    prod_pipe[0] <= p;
    for (int i = 1; i < PIPE_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
  end
  assign e = prod_pipe[PIPE_LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned val;
    int          cycle;
  } exp_t;

  exp_t             exp_q [$];
  logic [WIDTH-1:0] mfa [$];
  logic [WIDTH-1:0] mfb [$];
  logic             mm_prev = 1'b0;

  always @(negedge clk) begin
    exp_t x;
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result_valid", 32'd1, 32'd0);
      end else begin
        x = exp_q.pop_front();
        chk("result", result, x.val);
        chk("result_cycle", cyc, x.cycle);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input int pa, input int pb);
    logic exp_rdy;
    next_cycle();
    pair_valid = 1'b1;
    pair_a     = WIDTH'(pa);
    pair_b     = WIDTH'(pb);
    exp_rdy    = (mfa.size() < DEPTH);
    @(negedge clk);
    chk("pair_ready", pair_ready, exp_rdy);
    if (exp_rdy) begin
      mfa.push_back(pair_a);
      mfb.push_back(pair_b);
    end
    next_cycle();
    pair_valid = 1'b0;
  endtask

  task automatic run_burst(input bit poke);
    int   t, n, t_done, set_cyc, idx;
    logic ei, em, eb, ed, emm;
    exp_t x;
    next_cycle();
    start   = 1'b1;
    t       = cyc;
    n       = mfa.size();
    set_cyc = 1 << 30;
    for (int k = 0; k < n; k++) begin
      x.cycle = t + 2 + (k + 1) * HOLD + PIPE_LAT;
      x.val   = int'(mfa[k]) * int'(mfb[k]);
      if (bad_53 && mfa[k] == 4'd5 && mfb[k] == 4'd3) begin
        x.val = 16;
        if (CHK && x.cycle < set_cyc) set_cyc = x.cycle;
      end
      exp_q.push_back(x);
    end
    t_done = (n == 0) ? t + 1 : t + 2 + n * HOLD + PIPE_LAT + 1;
    for (int c = t; c <= t_done + 1; c++) begin
      if (c > t) begin
        next_cycle();
        start      = 1'b0;
        pair_valid = 1'b0;
        if (poke && c == t + 3) begin
          start      = 1'b1;
          pair_valid = 1'b1;
          pair_a     = 4'd7;
          pair_b     = 4'd7;
        end
      end
      @(negedge clk);
      ei  = (n > 0) && c >= t + 1 && c < t_done;
      em  = (n > 0) && c >= t + 2 && c <= t + 1 + n * HOLD;
      eb  = c >= t + 1 && c <= t_done;
      ed  = (c == t_done);
      emm = (c == t) ? mm_prev : (c >= set_cyc);
      chk("ctrl_inc_mul_busy_done_mm",
          {increment_enable, multiply_enable, busy, done, mismatch}, {ei, em, eb, ed, emm});
      if (n > 0 && c >= t + 1 && c <= t + 1 + n * HOLD) begin
        idx = (c <= t + 1) ? 0 : (c - t - 2) / HOLD;
        chk("operands", {a, b}, {mfa[idx], mfb[idx]});
      end else begin
        chk("operands_zero", {a, b}, 32'd0);
      end
      if (c == t || (poke && c == t + 3)) chk("ready_gated", pair_ready, 32'd0);
    end
    mm_prev = (set_cyc <= t_done + 1);
    mfa.delete();
    mfb.delete();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    pair_valid = 1'b0;
    pair_a     = '0;
    pair_b     = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {increment_enable, multiply_enable, busy, done, result_valid, mismatch, pair_ready, a, b, result},
        32'd0);
    start = 1'b0;
    #1;
    chk("reset_ready_follows_start", pair_ready, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic burst
    load_pair(2, 4);
    load_pair(5, 3);
    load_pair(2, 10);
    run_burst(1'b0);

    // full FIFO: fifth pair refused
    load_pair(1, 1);
    load_pair(3, 7);
    load_pair(15, 15);
    load_pair(9, 2);
    load_pair(4, 4);
    run_burst(1'b0);

    // empty start
    run_burst(1'b0);

    // corrupted 5*3 from the stage, then a start that clears the flag
    bad_53 = 1'b1;
    load_pair(5, 3);
    load_pair(6, 2);
    run_burst(1'b0);
    bad_53 = 1'b0;
    run_burst(1'b0);

    // start and load attempts while busy
    load_pair(3, 3);
    load_pair(4, 5);
    load_pair(7, 1);
    run_burst(1'b1);

    // reset during pair 1's hold
    load_pair(8, 8);
    load_pair(9, 9);
    load_pair(10, 10);
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (3) next_cycle();
    chk("pre_reset_in_run", multiply_enable, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs",
        {increment_enable, multiply_enable, busy, done, result_valid, mismatch, a, b, result}, 32'd0);
    chk("midrun_reset_ready", pair_ready, 32'd1);
    mfa.delete();
    mfb.delete();
    mm_prev = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
    repeat (8) next_cycle();

    // FIFO must be empty after reset: empty start, then four loads all accepted
    run_burst(1'b0);
    load_pair(11, 13);
    load_pair(15, 1);
    load_pair(0, 9);
    load_pair(12, 12);
    run_burst(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
